// File: rtl/uart_tx_fsm_if.sv
// uart_tx_fsm_if: request/data/status bundle between system logic and the UART transmitter.
interface uart_tx_fsm_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] data_in;
    logic                 Bit_out;
    logic                 bussy;
    logic                 done;

    modport master (output start, data_in, input Bit_out, bussy, done);
    modport slave  (input start, data_in, output Bit_out, bussy, done);
endinterface

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: 8N1 UART transmitter, one frame per accepted start request.
`ifndef SAMPLING_FACTOR
`define SAMPLING_FACTOR 16
`endif
module uart_tx_fsm #(
    parameter int CLKS_PER_BIT = `SAMPLING_FACTOR,
    parameter int DATA_BITS    = 8
) (
    input logic          clk,
    input logic          rst,
    uart_tx_fsm_if.slave bus
);
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic [1:0] IDLE = 2'd0, START_BIT = 2'd1, SEND_BITS = 2'd2, STOP_BIT = 2'd3;

    logic [1:0]           state;
    logic [DW-1:0]        div;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic                 bit_out;
    logic                 bussy;
    logic                 done;
    logic                 bit_end;

    assign bit_end     = div == DIV_LAST;
    assign bus.Bit_out = bit_out;
    assign bus.bussy   = bussy;
    assign bus.done    = done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            idx     <= '0;
            shift   <= '0;
            bit_out <= 1'b1;
            bussy   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            div  <= (state == IDLE || bit_end) ? '0 : div + 1'b1;
            case (state)
                IDLE: begin
                    bit_out <= ~bus.start;
                    bussy   <= bus.start;
                    if (bus.start) begin
                        state <= START_BIT;
                        shift <= bus.data_in;
                    end
                end
                START_BIT: if (bit_end) begin
                    state   <= SEND_BITS;
                    idx     <= '0;
                    bit_out <= shift[0];
                end
                // the next data bit is shift[1] because the register shifts on this same edge
                SEND_BITS: if (bit_end) begin
                    shift   <= shift >> 1;
                    idx     <= idx + 1'b1;
                    state   <= (idx == IDX_LAST) ? STOP_BIT : SEND_BITS;
                    bit_out <= (idx == IDX_LAST) ? 1'b1 : shift[1];
                end
                STOP_BIT: if (bit_end) begin
                    state <= IDLE;
                    bussy <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    bit_out <= 1'b1;
                    bussy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: random and directed frames checked against a per-cycle frame model and a loopback receiver.
module tb_uart_tx_fsm;
    localparam int CPB = 4;
    localparam int DB  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [2:0] exp_q[$];
    logic [2:0] exp_v;
    logic [7:0] sent_q[$];
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;

    uart_tx_fsm_if #(.DATA_BITS(DB)) bus ();
    uart_tx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // expected {Bit_out, bussy, done} after the coming edge, built from whole frames
    task automatic model_edge();
        logic lvl;
        if (rst) begin
            exp_q.delete();
            sent_q.delete();
            exp_v = 3'b100;
        end else if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
        end else if (bus.start) begin
            sent_q.push_back(bus.data_in);
            for (int b = 0; b < DB + 2; b++) begin
                lvl = (b == 0) ? 1'b0 : (b == DB + 1) ? 1'b1 : bus.data_in[b-1];
                for (int c = 0; c < CPB; c++) exp_q.push_back({lvl, 2'b10});
            end
            exp_q.push_back(3'b101);
            exp_v = exp_q.pop_front();
        end else begin
            exp_v = 3'b100;
        end
    endtask

    task automatic rx_sample();
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (bus.Bit_out == 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= 6 && rx_cnt <= 34 && rx_cnt % 4 == 2) rx_byte[(rx_cnt-6)/4] = bus.Bit_out;
            if (rx_cnt == 38) begin
                check("rx_stop", {31'd0, bus.Bit_out}, 32'd1);
                check("rx_pending", sent_q.size(), 32'd1);
                if (sent_q.size() > 0) check("rx_byte", {24'd0, rx_byte}, {24'd0, sent_q.pop_front()});
            end
            if (rx_cnt == 39) rx_act = 1'b0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("bit_out", {31'd0, bus.Bit_out}, {31'd0, exp_v[2]});
        check("bussy", {31'd0, bus.bussy}, {31'd0, exp_v[1]});
        check("done", {31'd0, bus.done}, {31'd0, exp_v[0]});
        rx_sample();
    endtask

    task automatic run_frame(input logic [7:0] d);
        bus.start   = 1'b1;
        bus.data_in = d;
        step();
        bus.start = 1'b0;
        while (exp_q.size() > 0) step();
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.data_in = '0;
        @(negedge clk);
        check("rst_bit_out", {31'd0, bus.Bit_out}, 32'd1);
        check("rst_bussy", {31'd0, bus.bussy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        step();
        rst = 1'b0;
        repeat (2) step();

        run_frame(8'hA5);
        repeat (3) step();

        bus.start   = 1'b1;
        bus.data_in = 8'h00;
        step();
        bus.data_in = 8'hFF;
        while (exp_q.size() > 0) step();
        step();
        bus.start = 1'b0;
        while (exp_q.size() > 0) step();
        repeat (2) step();

        bus.start   = 1'b1;
        bus.data_in = 8'h96;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        bus.start   = 1'b1;
        bus.data_in = 8'h3C;
        step();
        bus.start = 1'b0;
        while (exp_q.size() > 0) step();
        repeat (6) step();

        bus.start   = 1'b1;
        bus.data_in = 8'h5A;
        step();
        bus.start = 1'b0;
        repeat (17) step();
        rst = 1'b1;
        #1;
        check("async_bit_out", {31'd0, bus.Bit_out}, 32'd1);
        check("async_bussy", {31'd0, bus.bussy}, 32'd0);
        check("async_done", {31'd0, bus.done}, 32'd0);
        step();
        rst = 1'b0;
        step();
        run_frame(8'h81);
        step();

        bus.start   = 1'b1;
        bus.data_in = 8'hC3;
        step();
        bus.start = 1'b0;
        while (exp_q.size() > 0) begin
            bus.data_in = 8'($urandom);
            step();
        end
        step();

        for (int b = 0; b < 256; b++) begin
            bus.start   = 1'b1;
            bus.data_in = 8'(b);
            step();
            while (exp_q.size() > 0) begin
                bus.start   = 1'($urandom);
                bus.data_in = 8'($urandom);
                step();
            end
            bus.start = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
